// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-side blocks of the core:
// the arbiter state encoding and the memory bus geometry.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int MEM_MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Unified memory port arbiter between instruction fetch and load/store.
// Data wins over fetch unless fetch has been passed over STARVE_LIMIT
// times in a row. One transaction in flight; the response is steered back
// to whichever side owns the current state.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_ready,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_ren,
  input  logic                i_dm_wen,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_wmask,
  output logic                o_dm_ready,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  // The streak counter is 4 bits wide, so the limit is compared at that width.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t            state_reg, state_next;
  logic [3:0]            streak_reg, streak_next;
  logic                  drop_reg, drop_next;
  logic                  grant_data, grant_fetch;
  logic                  data_pend, starve;

  logic                  mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0]     mem_addr_reg;
  logic [DATA_W-1:0]     mem_wdata_reg;
  logic [DATA_W/8-1:0]   mem_wmask_reg;

  // A simultaneous read and write request is treated as a write.
  assign data_pend = i_dm_ren | i_dm_wen;
  // Fetch has waited long enough: the next IDLE decision must go to fetch.
  assign starve    = i_if_req && (streak_reg == LIMIT);

  // Arbitration decision, starvation streak and flush-drop tracking.
  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    drop_next   = drop_reg;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    unique case (state_reg)
      IDLE: begin
        drop_next = 1'b0;
        if (data_pend && !starve) begin
          grant_data = 1'b1;
          state_next = DATA;
        end else if (i_if_req) begin
          grant_fetch = 1'b1;
          state_next  = FETCH;
        end
        if (!i_if_req || grant_fetch) begin
          streak_next = 4'd0;
        end else if (grant_data && (streak_reg < LIMIT)) begin
          streak_next = streak_reg + 4'd1;
        end
      end
      FETCH: begin
        // A flush turns the in-flight fetch into a silent access.
        if (i_if_flush) drop_next = 1'b1;
        if (i_mem_ack) begin
          state_next = IDLE;
          drop_next  = 1'b0;
        end
      end
      DATA: begin
        if (i_mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      streak_reg <= 4'd0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      drop_reg   <= drop_next;
    end
  end

  // Memory port registers: captured on the grant, frozen until the ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wmask_reg <= '0;
    end else if (grant_data) begin
      mem_req_reg   <= 1'b1;
      mem_we_reg    <= i_dm_wen;
      mem_addr_reg  <= i_dm_addr;
      mem_wdata_reg <= i_dm_wdata;
      mem_wmask_reg <= i_dm_wmask;
    end else if (grant_fetch) begin
      mem_req_reg   <= 1'b1;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= i_if_addr;
      mem_wdata_reg <= '0;
      mem_wmask_reg <= '0;
    end else if ((state_reg != IDLE) && i_mem_ack) begin
      mem_req_reg   <= 1'b0;
    end
  end

  assign o_mem_req   = mem_req_reg;
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_wmask = mem_wmask_reg;

  // Responses are same-cycle with the ack; read data is a plain pass-through.
  assign o_dm_ready  = (state_reg == DATA) && i_mem_ack;
  assign o_if_ready  = (state_reg == FETCH) && i_mem_ack && !drop_reg;
  assign o_dm_rdata  = i_mem_rdata;
  assign o_if_rdata  = i_mem_rdata;
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between instruction fetch and the data access requested by the decoded load/store controls (mem_ren/mem_wen). Sits between the fetch stage, the data-memory stage and the memory wrapper. Arbitrates with data-over-fetch priority plus a starvation guard, holds one outstanding transaction at a time, and routes the response back to its owner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; range 1..15
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_if_req  input  1  fetch request; level, held until o_if_ready
- i_if_addr  input  ADDR_W  fetch address
- i_if_flush  input  1  discard in-flight fetch response (taken branch/jump)
- o_if_ready  output  1  fetch response valid, one-cycle pulse
- o_if_rdata  output  DATA_W  fetch data
- i_dm_ren  input  1  data read request; level, held until o_dm_ready
- i_dm_wen  input  1  data write request; level, held until o_dm_ready
- i_dm_addr  input  ADDR_W  data address
- i_dm_wdata  input  DATA_W  store data
- i_dm_wmask  input  DATA_W/8  byte enables
- o_dm_ready  output  1  data response/write done, one-cycle pulse
- o_dm_rdata  output  DATA_W  load data
- o_mem_req  output  1  memory request, held until i_mem_ack
- o_mem_we  output  1  1 = write
- o_mem_addr  output  ADDR_W  registered address
- o_mem_wdata  output  DATA_W  registered store data
- o_mem_wmask  output  DATA_W/8  registered byte enables
- i_mem_ack  input  1  memory completion, one cycle
- i_mem_rdata  input  DATA_W  read data, valid with i_mem_ack
- o_busy  output  1  transaction outstanding (state != IDLE)

## Operation
- States: IDLE, FETCH, DATA.
- IDLE: data pending = i_dm_ren | i_dm_wen. Grant DATA if data pending and not (i_if_req and streak == STARVE_LIMIT); else FETCH if i_if_req; else stay.
- On grant edge: register addr/wdata/wmask; o_mem_req <= 1; o_mem_we <= i_dm_wen (DATA only; FETCH forces 0). Registered values do not follow inputs until next grant.
- i_dm_ren and i_dm_wen both high: treated as write.
- FETCH/DATA: hold o_mem_req and all o_mem_* stable until i_mem_ack; on ack edge o_mem_req <= 0, state <= IDLE.
- o_dm_ready = (state == DATA) & i_mem_ack, combinational.
- o_if_ready = (state == FETCH) & i_mem_ack & ~drop, combinational.
- o_if_rdata, o_dm_rdata = i_mem_rdata pass-through; meaningful only with ready.
- Flush: i_if_flush in FETCH sets drop; the memory access completes but o_if_ready is suppressed; drop clears on return to IDLE. Flush in IDLE/DATA: no effect.
- Starvation streak (4-bit): +1 on DATA grant while i_if_req high; clear on FETCH grant or any IDLE cycle with i_if_req low; saturates at STARVE_LIMIT.
- i_mem_ack in IDLE: ignored.
- Reset (async, any state): state IDLE, o_mem_req/o_mem_we 0, o_mem_addr/wdata/wmask 0, streak 0, drop 0, o_busy 0, both readys 0.

## Timing
- Request seen in IDLE at cycle N -> o_mem_req high at N+1.
- Ack at cycle M -> owner ready at M (same cycle), arbiter IDLE at M+1.
- Minimum latency 1 cycle (ack at N+1); back-to-back grants separated by one IDLE cycle; peak throughput one transaction per 2 cycles.
- Requester may change address/request in the cycle after its ready.

## Structure
- Shared package riscv_pkg: arbiter state enum (IDLE, FETCH, DATA), MEM_MASK_W = DATA_W/8.
- Single module; no sub-module needed.

## Test plan
- Fetch only, addr 0x100, memory acks 1 cycle after req -> o_mem_req at N+1, o_mem_we 0, o_if_ready with rdata 0xDEADBEEF at N+1.
- Fetch and load both pending in IDLE -> DATA granted first; fetch granted after the load's ack plus one IDLE cycle.
- Continuous data requests, fetch pending, STARVE_LIMIT 4 -> 4 DATA grants, then 1 FETCH grant, then DATA resumes.
- Store addr 0x200, wdata 0x12345678, mask 4'b0011; change inputs while waiting 5 cycles for ack -> o_mem_* stay at the granted values, o_mem_we 1, o_dm_ready on ack.
- i_if_flush asserted mid-FETCH -> ack arrives, o_if_ready stays 0; the next fetch completes normally.
- i_rst_n low during DATA with ack pending -> o_mem_req 0 immediately, state IDLE; a late ack after reset produces no ready.
